// File: rtl/mvu_apb_csr_bridge.sv
// APB slave that forwards CSR accesses to an MVU array over a req/ack channel.
// Ports: APB (psel/penable/pwrite/paddr/pwdata/pstrb -> prdata/pready/pslverr),
//   CSR master (csr_req/csr_mvu/csr_addr/csr_we/csr_wdata <- csr_ack/csr_rdata).
module mvu_apb_csr_bridge #(
  parameter int NMVU           = 8,
  parameter int APB_ADDR_WIDTH = 15,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT        = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        psel,
  input  logic                        penable,
  input  logic                        pwrite,
  input  logic [APB_ADDR_WIDTH-1:0]   paddr,
  input  logic [APB_DATA_WIDTH-1:0]   pwdata,
  input  logic [APB_DATA_WIDTH/8-1:0] pstrb,
  output logic [APB_DATA_WIDTH-1:0]   prdata,
  output logic                        pready,
  output logic                        pslverr,
  output logic                        csr_req,
  output logic [APB_ADDR_WIDTH-13:0]  csr_mvu,
  output logic [11:0]                 csr_addr,
  output logic                        csr_we,
  output logic [APB_DATA_WIDTH-1:0]   csr_wdata,
  input  logic                        csr_ack,
  input  logic [APB_DATA_WIDTH-1:0]   csr_rdata
);

  localparam int MW = APB_ADDR_WIDTH - 12;
  localparam int DW = APB_DATA_WIDTH;
  localparam logic [31:0] NMVU_L = 32'(NMVU);
  localparam logic [7:0] TO = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic [MW-1:0] mvu_q, mvu_d;
  logic [11:0]   addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;

  logic          acc;
  logic          in_rng;
  logic          mvu_ok;
  logic          wr_ok;
  logic          legal;

  // Decode straight from the bus so the
  // legality decision is made on the
  // accepting edge.
  always_comb begin
    acc    = psel && penable;
    in_rng = (paddr[11:0] >= 12'hf20) &&
             (paddr[11:0] <= 12'hf63);
    mvu_ok = ({{(32-MW){1'b0}}, paddr[APB_ADDR_WIDTH-1:12]}
              < NMVU_L);
    // Status register is read-only and
    // partial writes are not supported.
    wr_ok  = (&pstrb) && (paddr[11:0] != 12'hf4e);
    legal  = in_rng && mvu_ok && (!pwrite || wr_ok);
  end

  always_comb begin
    state_d = state_q;
    mvu_d   = mvu_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (acc) begin
          mvu_d   = paddr[APB_ADDR_WIDTH-1:12];
          addr_d  = paddr[11:0];
          we_d    = pwrite;
          wdata_d = pwdata;
          rdata_d = '0;
          cnt_d   = '0;
          err_d   = !legal;
          state_d = legal ? REQ : RESP;
        end
      end
      REQ, WAIT: begin
        // An ack on the timeout cycle still
        // completes the access normally.
        if (csr_ack) begin
          rdata_d = we_q ? '0 : csr_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == TO) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mvu_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mvu_q   <= mvu_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    csr_req   = (state_q == REQ) || (state_q == WAIT);
    csr_mvu   = mvu_q;
    csr_addr  = addr_q;
    csr_we    = we_q;
    csr_wdata = wdata_q;
    pready    = (state_q == RESP);
    pslverr   = pready && err_q;
    prdata    = (pready && !err_q) ? rdata_q : '0;
  end

endmodule

// File: tb/tb_mvu_apb_csr_bridge.sv
// Randomized bench for mvu_apb_csr_bridge with a
// transaction-level timing/response reference model.
module tb_mvu_apb_csr_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [14:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        csr_req;
  logic [2:0]  csr_mvu;
  logic [11:0] csr_addr;
  logic        csr_we;
  logic [31:0] csr_wdata;
  logic        csr_ack;
  logic [31:0] csr_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mvu_apb_csr_bridge #(
    .NMVU(8),
    .APB_ADDR_WIDTH(15),
    .APB_DATA_WIDTH(32),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .paddr(paddr),
    .pwdata(pwdata),
    .pstrb(pstrb),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr),
    .csr_req(csr_req),
    .csr_mvu(csr_mvu),
    .csr_addr(csr_addr),
    .csr_we(csr_we),
    .csr_wdata(csr_wdata),
    .csr_ack(csr_ack),
    .csr_rdata(csr_rdata)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input bit w,
                                  input logic [14:0] a,
                                  input logic [3:0] s);
    int csr;
    int idx;
    csr = int'(a[11:0]);
    idx = int'(a[14:12]);
    if (csr < 'hf20 || csr > 'hf63) return 0;
    if (idx >= 8) return 0;
    if (w && (s != 4'hf || csr == 'hf4e)) return 0;
    return 1;
  endfunction

  // One APB access. d = cycles of csr_req before
  // ack (0 = ack in first req cycle); d >= TO
  // means no ack at all. drop = master releases
  // psel early.
  task automatic txn(input bit w,
                     input logic [14:0] a,
                     input logic [31:0] wd,
                     input logic [3:0] s,
                     input int d,
                     input logic [31:0] rd,
                     input bit drop);
    bit lg;
    bit tmo;
    int last_req;
    int resp;
    logic [31:0] exp_rd;
    lg  = is_legal(w, a, s);
    tmo = lg && (d >= TO);
    if (!lg) begin
      last_req = 0;
      resp     = 1;
    end else if (tmo) begin
      last_req = TO;
      resp     = TO + 1;
    end else begin
      last_req = 1 + d;
      resp     = 2 + d;
    end
    exp_rd = (!lg || tmo || w) ? 32'h0 : rd;

    @(negedge clk);
    psel      = 1'b1;
    penable   = 1'b0;
    pwrite    = w;
    paddr     = a;
    pwdata    = wd;
    pstrb     = s;
    csr_ack   = 1'($urandom_range(0, 1));
    csr_rdata = $urandom;
    check("setup_req", {31'd0, csr_req}, 32'd0);
    check("setup_pready", {31'd0, pready}, 32'd0);

    @(negedge clk);
    penable = 1'b1;
    csr_ack = 1'b0;
    check("n_req", {31'd0, csr_req}, 32'd0);

    for (int c = 1; c <= resp + 1; c++) begin
      @(negedge clk);
      if (c == resp) begin
        csr_ack   = 1'($urandom_range(0, 1));
        csr_rdata = $urandom;
      end else if (lg && !tmo && c == 1 + d) begin
        csr_ack   = 1'b1;
        csr_rdata = rd;
      end else begin
        csr_ack   = 1'b0;
        csr_rdata = $urandom;
      end
      if (c == resp + 1 || (drop && c == 2)) begin
        psel    = 1'b0;
        penable = 1'b0;
      end
      check("csr_req", {31'd0, csr_req},
            {31'd0, lg && c <= last_req});
      if (lg && c <= last_req) begin
        check("csr_mvu", {29'd0, csr_mvu},
              {29'd0, a[14:12]});
        check("csr_addr", {20'd0, csr_addr},
              {20'd0, a[11:0]});
        check("csr_we", {31'd0, csr_we}, {31'd0, w});
        check("csr_wdata", csr_wdata, wd);
      end
      check("pready", {31'd0, pready},
            {31'd0, c == resp});
      if (c == resp) begin
        check("pslverr", {31'd0, pslverr},
              {31'd0, !lg || tmo});
        check("prdata", prdata, exp_rd);
      end else begin
        check("pslverr_idle", {31'd0, pslverr}, 32'd0);
        check("prdata_idle", prdata, 32'd0);
      end
    end
    csr_ack = 1'b0;
  endtask

  task automatic reset_mid_wait();
    @(negedge clk);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 15'h5f30;
    pwdata  = 32'h0;
    pstrb   = 4'h0;
    csr_ack = 1'b0;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    check("rst_pre_req", {31'd0, csr_req}, 32'd1);
    @(negedge clk);
    check("rst_wait_req", {31'd0, csr_req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_req", {31'd0, csr_req}, 32'd0);
    check("rst_async_addr", {20'd0, csr_addr}, 32'd0);
    check("rst_async_mvu", {29'd0, csr_mvu}, 32'd0);
    check("rst_async_pready", {31'd0, pready}, 32'd0);
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    rst     = 1'b0;
    csr_ack = 1'b1;
    csr_rdata = 32'hbad0_bad0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      csr_ack = 1'b0;
      check("post_rst_pready", {31'd0, pready}, 32'd0);
      check("post_rst_req", {31'd0, csr_req}, 32'd0);
    end
  endtask

  initial begin
    logic [14:0] a;
    logic [3:0]  s;
    bit          w;
    rst       = 1'b1;
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    paddr     = '0;
    pwdata    = '0;
    pstrb     = '0;
    csr_ack   = 1'b0;
    csr_rdata = '0;
    #12;
    check("rst_req", {31'd0, csr_req}, 32'd0);
    check("rst_we", {31'd0, csr_we}, 32'd0);
    check("rst_wdata", csr_wdata, 32'd0);
    check("rst_pready", {31'd0, pready}, 32'd0);
    check("rst_pslverr", {31'd0, pslverr}, 32'd0);
    check("rst_prdata", prdata, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    txn(1, 15'h3f20, 32'h1234, 4'hf, 1, 32'h0, 0);
    txn(0, 15'h0f4e, 32'h55, 4'h0, 0, 32'hdead_beef, 0);
    txn(1, 15'h1f64, 32'h1, 4'hf, 0, 32'h0, 0);
    txn(1, 15'h2f4e, 32'h2, 4'hf, 0, 32'h0, 0);
    txn(1, 15'h0f30, 32'h3, 4'h3, 0, 32'h0, 0);
    txn(0, 15'h4f1f, 32'h0, 4'h0, 0, 32'h9, 0);
    txn(0, 15'h2f40, 32'h0, 4'h0, TO, 32'h77, 0);
    txn(0, 15'h6f63, 32'h0, 4'h0, TO - 1, 32'hcafe, 0);
    txn(1, 15'h7f21, 32'h99, 4'hf, 2, 32'h0, 1);
    reset_mid_wait();
    txn(0, 15'h1f50, 32'h0, 4'h0, 1, 32'h0bad_f00d, 0);

    for (int m = 0; m < 8; m++) begin
      a = {3'(m), 12'hf44};
      txn(0, a, 32'h0, 4'h0, $urandom_range(0, 2),
          32'h1000_0000 + 32'(m), 0);
    end

    for (int i = 0; i < 150; i++) begin
      w = 1'($urandom_range(0, 1));
      a[14:12] = 3'($urandom_range(0, 7));
      a[11:0]  = 12'(12'hf1c + $urandom_range(0, 75));
      if ($urandom_range(0, 9) == 0) a = 15'($urandom);
      s = ($urandom_range(0, 3) == 0) ?
          4'($urandom) : 4'hf;
      txn(w, a, $urandom, s, $urandom_range(0, TO + 1),
          $urandom, 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mvu_apb_csr_bridge.md
MVU_APB_CSR_BRIDGE -- requirements
Module: mvu_apb_csr_bridge

Interface
REQ-001 The block SHALL have the following parameters:
- NMVU, default 8: number of MVUs.
- APB_ADDR_WIDTH, default 15: APB address width.
- APB_DATA_WIDTH, default 32: APB data width.
- TIMEOUT, default 255: maximum ack-wait cycles, 1..255.

REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- psel  in  1  APB select.
- penable  in  1  APB enable.
- pwrite  in  1  APB direction, 1 = write.
- paddr  in  15  APB address: [14:12] MVU index, [11:0] CSR number.
- pwdata  in  32  APB write data.
- pstrb  in  4  APB write strobes.
- prdata  out  32  APB read data.
- pready  out  1  APB ready.
- pslverr  out  1  APB error.
- csr_req  out  1  CSR request to the MVU array.
- csr_mvu  out  3  target MVU index.
- csr_addr  out  12  CSR number.
- csr_we  out  1  CSR write enable.
- csr_wdata  out  32  CSR write data.
- csr_ack  in  1  CSR completion from the MVU array.
- csr_rdata  in  32  CSR read data, valid with csr_ack.

Function
REQ-003 The FSM SHALL have four states: IDLE, REQ, WAIT, RESP.

REQ-004 In IDLE, psel=1 with penable=1 SHALL latch paddr, pwrite, pwdata and pstrb, and decode the request.

REQ-005 The request SHALL be legal only if csr_addr is in 12'hf20..12'hf63 inclusive, the MVU index is < NMVU, and, for a write, pstrb==4'hf and csr_addr!=12'hf4e (the status register is read-only).

REQ-006 An illegal request SHALL go to RESP with the error flag set; no csr_req is issued.

REQ-007 A legal request SHALL go to REQ; csr_req SHALL be asserted from the next cycle, with csr_mvu/csr_addr/csr_we/csr_wdata driven from the latched values.

REQ-008 csr_req SHALL be level-held until csr_ack is sampled high (REQ then WAIT); it SHALL deassert in the cycle after that ack.
- For a read, csr_rdata SHALL be captured on the ack edge.
- For a write, the captured data SHALL be 0.

REQ-009 csr_ack sampled while csr_req=0 SHALL be ignored.

REQ-010 A 8-bit wait counter SHALL clear on entry to REQ and increment each cycle without an ack.
- On reaching TIMEOUT, csr_req SHALL drop and the FSM SHALL go to RESP with the error flag set.
- An ack arriving in the same cycle the count reaches TIMEOUT SHALL win: normal completion.

REQ-011 In RESP, pready=1 for exactly one cycle; pslverr equals the error flag; prdata equals the captured data, or 0 on error.
- The next state SHALL be IDLE.

REQ-012 Outside RESP, pready=0, pslverr=0 and prdata=0.

REQ-013 Latency: with APB access seen at cycle N and csr_ack at cycle N+k (k≥1), pready SHALL be 1 at cycle N+k+1.
- Minimum latency is N+2.
- An illegal request SHALL respond at N+1.

REQ-014 If psel drops before RESP (protocol violation):
- the CSR operation SHALL still complete or time out;
- pready SHALL still pulse one cycle;
- the FSM SHALL then return to IDLE.

REQ-015 A new APB access SHALL be accepted only in IDLE; a psel&penable present in the RESP cycle SHALL be ignored.

REQ-016 csr_mvu, csr_addr, csr_we and csr_wdata SHALL hold stable while csr_req=1.

Reset
REQ-017 While rst=1, the following SHALL hold immediately (asynchronously):
- state=IDLE;
- csr_req=0, csr_we=0, csr_mvu=0, csr_addr=0, csr_wdata=0;
- pready=0, pslverr=0, prdata=0;
- counter=0, error flag=0.

REQ-018 Reset asserted mid-transaction SHALL abort it with no APB response. A csr_ack arriving after reset release SHALL be ignored.

Verification
REQ-019 Write paddr=15'h3f20, pwdata=32'h1234, pstrb=4'hf; csr_ack 2 cycles after csr_req -> csr_mvu=3, csr_addr=12'hf20, csr_we=1, csr_wdata=32'h1234; pready at N+3, pslverr=0.

REQ-020 Read paddr=15'h0f4e; csr_ack immediately with csr_rdata=32'hdead_beef -> prdata=32'hdead_beef, pready at N+2, csr_we=0.

REQ-021 Illegal accesses: write paddr=15'h1f64, write to 12'hf4e, and write with pstrb=4'h3 -> each gives pready at N+1, pslverr=1, and no csr_req pulse.

REQ-022 Read with TIMEOUT=4 and csr_ack held 0 -> csr_req high 4 cycles then low; pready=1, pslverr=1, prdata=0.

REQ-023 rst pulsed while in WAIT -> csr_req=0 immediately, no pready; a subsequent legal read completes normally.

REQ-024 Spurious csr_ack in IDLE, plus back-to-back APB reads to MVUs 0..7 -> spurious ack ignored; each read returns its own csr_rdata in order.
